// File: rtl/spi_image_buffer.sv
// Byte-to-bitmap assembler: packs SPI bytes LSB-first into the BNN image register
// and reports fill state (empty/filling/full, overflow) to the control FSM.
module spi_image_buffer #(
    parameter int IMG_BITS = 904,
    parameter int PIXELS   = 900,
    parameter int ADDR_W   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_buffer,
    input  logic                buffer_write_enable,
    input  logic [7:0]          buffer_data_in,
    output logic [ADDR_W-1:0]   write_addr,
    output logic                buffer_empty,
    output logic                buffer_full,
    output logic                write_ack,
    output logic                overflow,
    output logic [IMG_BITS-1:0] img_out
);

    localparam int BYTES     = IMG_BITS / 8;
    localparam int LAST_SLOT = BYTES - 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL
    } state_t;

    state_t     state;
    logic [7:0] lane_data;

    // Bits of the addressed lane that fall in the padding region are forced to 0.
    always_comb begin
        // NOTE: default first so every path assigns lane_data and no latch is inferred.
        lane_data = buffer_data_in;
        for (int i = 0; i < 8; i++) begin
            if (int'(write_addr) * 8 + i >= PIXELS) lane_data[i] = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the image register is reset too: a partial image must never leak out.
            state        <= ST_EMPTY;
            write_addr   <= '0;
            buffer_empty <= 1'b1;
            buffer_full  <= 1'b0;
            write_ack    <= 1'b0;
            overflow     <= 1'b0;
            img_out      <= '0;
        end else if (clear_buffer) begin
            state        <= ST_EMPTY;
            write_addr   <= '0;
            buffer_empty <= 1'b1;
            buffer_full  <= 1'b0;
            write_ack    <= 1'b0;
            overflow     <= 1'b0;
            img_out      <= '0;
        end else begin
            write_ack <= 1'b0;
            case (state)
                // EMPTY is FILLING with write_addr == 0, so both share the store path.
                ST_EMPTY, ST_FILLING: begin
                    if (buffer_write_enable) begin
                        for (int b = 0; b < BYTES; b++) begin
                            if (write_addr == ADDR_W'(b)) img_out[b*8 +: 8] <= lane_data;
                        end
                        write_addr   <= write_addr + ADDR_W'(1);
                        write_ack    <= 1'b1;
                        buffer_empty <= 1'b0;
                        if (write_addr == ADDR_W'(LAST_SLOT)) begin
                            state       <= ST_FULL;
                            buffer_full <= 1'b1;
                        end else begin
                            state <= ST_FILLING;
                        end
                    end
                end
                ST_FULL: begin
                    if (buffer_write_enable) overflow <= 1'b1;
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: doc/spi_image_buffer.md
# spi_image_buffer

Byte-to-bitmap assembler between the SPI byte receiver and the BNN core. It accepts 8-bit words strobed by the control FSM, packs them LSB-first into a 904-bit image register, and reports fill state to the FSM and debug monitor. The BNN core and debug monitor read `img_out` in parallel once `buffer_full` is high. The 30×30 pixel map is `img_out[row*30+col]`.

## Interface
Parameters:
- `IMG_BITS`, 904: width of image register; must be a multiple of 8.
- `PIXELS`, 900: number of valid pixel bits; bits `[IMG_BITS-1:PIXELS]` are padding.
- `ADDR_W`, 10: width of byte address/count.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear_buffer`  in  1  synchronous clear request from the FSM.
- `buffer_write_enable`  in  1  write strobe; one byte is accepted per high cycle.
- `buffer_data_in`  in  8  byte to store; bit i maps to pixel `addr*8+i`.
- `write_addr`  out  ADDR_W  next byte slot to be written (0..113), equal to the bytes stored so far.
- `buffer_empty`  out  1  high when no bytes are stored.
- `buffer_full`  out  1  high when all `IMG_BITS/8` (113) bytes are stored.
- `write_ack`  out  1  one-cycle pulse on the cycle after a byte is accepted.
- `overflow`  out  1  sticky flag: a write was attempted while full.
- `img_out`  out  IMG_BITS  assembled image.

## Operation
- FSM states are EMPTY, FILLING and FULL. Reset state is EMPTY.
- EMPTY:
  - A write stores the byte at slot 0.
  - `write_addr` becomes 1.
  - State moves to FILLING.
- FILLING:
  - A write stores the byte at `write_addr*8 +: 8` and increments `write_addr`.
  - When the accepted byte is slot 112, the state moves to FULL.
- FULL:
  - Writes are dropped and `img_out` is unchanged.
  - `overflow` is set and holds until a clear or reset.
  - `write_ack` is not pulsed.
- `clear_buffer` in any state has the following effect on the next edge:
  - `img_out` is zeroed.
  - `write_addr`, `overflow` and `write_ack` go to 0.
  - State returns to EMPTY.
- `clear_buffer` has priority over a simultaneous write. That write is discarded and not acked.
- Padding bits `img_out[IMG_BITS-1:PIXELS]` are always 0. The upper 4 bits of byte 112 are discarded.
- `write_addr` saturates at 113 and never wraps.
- Only the addressed byte lane changes on a write. All other bits hold.
- `buffer_empty` and `buffer_full` are registered state decodes. They are never both high.
- After reset, each stored pixel bit is the value written to it since the last clear.

## Timing
- Reset (asynchronous, on `rst_n` low):
  - `img_out`, `write_addr`, `write_ack`, `overflow` and `buffer_full` go to 0.
  - `buffer_empty` goes to 1.
  - This holds regardless of any fill in progress. A partial image is lost.
- Write latency is 1 cycle. For a write sampled at edge N:
  - the byte is visible on `img_out` after edge N;
  - `write_addr` is incremented after edge N;
  - `write_ack` is high for the cycle following edge N.
- Fill-state flags:
  - `buffer_empty` falls after the edge that accepts byte 0.
  - `buffer_full` rises after the edge that accepts byte 112.
  - Both flags update in the same cycle as `write_addr`.
- Back-to-back writes on consecutive cycles are supported at full rate. A full image takes 113 cycles minimum.
- Clear latency is 1 cycle. All outputs reach their reset values after the clear edge.
- `overflow` rises 1 cycle after the first rejected write.
- No combinational path from any input to any output.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle, with no clock.
  - Required: `buffer_empty`=1, `buffer_full`=0, `write_addr`=0, `img_out`=0 immediately.
- **Full fill:** 113 consecutive writes of 0xA5.
  - Required: `write_addr` steps 1..113 and `write_ack` is high for 113 cycles.
  - Required: `buffer_full` rises after the 113th edge.
  - Required: `img_out[899:0]` holds the repeating pattern 1,0,1,0,0,1,0,1 (LSB first) and `img_out[903:900]`=0.
- **Overflow:** from full, write 0xFF.
  - Required: `img_out` is unchanged, `write_addr`=113, no `write_ack`.
  - Required: `overflow`=1 next cycle and it stays 1 across idle cycles.
- **Clear with write:** after 5 writes, assert `clear_buffer` together with a write of 0x3C.
  - Required next cycle: `write_addr`=0, `buffer_empty`=1, `img_out`=0, no `write_ack`.
- **Reset mid-fill:** after 40 writes, pulse `rst_n` low, then write 0x01.
  - Required: `img_out[0]`=1, all other bits 0, `write_addr`=1.
- **Lane isolation:** write 0xFF to slot 0, then 0x00 to slot 1.
  - Required: `img_out[7:0]`=0xFF and `img_out[15:8]`=0x00.
